// File: rtl/c3lib_hs4_pkg.sv
// Shared types for the 4-phase source-side handshake.
// State encoding plus the phase counter width helper.
package c3lib_hs4_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } hs4_state_e;

   // Bits needed to count 0..tmax, never fewer than one.
   function automatic int cnt_width(input int tmax);
      int w;
      w = $clog2(tmax + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/c3lib_sync_srst_behav.sv
// Single-bit multi-flop synchronizer with synchronous reset.
// Instantiated as its own hierarchy so the flop chain stays intact.
module c3lib_sync_srst_behav #(
   parameter logic RESET_VAL   = 1'b0,
   parameter int   SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic data_out
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst)
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
   end

   assign data_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c3lib_hs4_src_sync.sv
// Source side of a 4-phase req/ack crossing: holds one word
// on hs_data while hs_req/hs_ack complete a full handshake.
module c3lib_hs4_src_sync
   import c3lib_hs4_pkg::*;
#(
   parameter int DWIDTH          = 8,
   parameter int ACK_SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC     = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src_valid,
   input  logic [DWIDTH-1:0] src_data,
   output logic              src_ready,
   output logic              hs_req,
   output logic [DWIDTH-1:0] hs_data,
   input  logic              hs_ack,
   output logic              tx_done,
   output logic              timeout_err
);

   localparam int CW = cnt_width(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT_CYC);

   hs4_state_e    state;
   hs4_state_e    state_nx;
   logic          ack_s;
   logic          run_q;
   logic          accept;
   logic          to_hit;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;

   (* dont_touch = "true" *)
   c3lib_sync_srst_behav #(
      .RESET_VAL   (1'b0),
      .SYNC_STAGES (ACK_SYNC_STAGES)
   ) u_ack_sync (
      .clk      (clk),
      .rst      (rst),
      .data_in  (hs_ack),
      .data_out (ack_s)
   );

   // run_q keeps src_ready low until the first edge out of reset.
   assign src_ready = (state == IDLE) & ~ack_s & run_q & ~rst;
   assign accept    = src_valid & src_ready;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = REQ_HI;
         REQ_HI:  if (ack_s)  state_nx = REQ_LO;
         REQ_LO:  if (!ack_s) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cnt_nx = '0;
      if (state != IDLE && state_nx == state) begin
         if (cnt != CNT_MAX)
            cnt_nx = cnt + 1'b1;
         else
            cnt_nx = cnt;
      end
   end

   assign to_hit = (TIMEOUT_CYC > 0) && (state != IDLE) &&
                   (cnt_nx == CNT_TO);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         run_q       <= 1'b0;
         hs_req      <= 1'b0;
         hs_data     <= '0;
         tx_done     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         run_q   <= 1'b1;
         tx_done <= (state == REQ_LO) && (state_nx == IDLE);
         if (accept) begin
            hs_data <= src_data;
            hs_req  <= 1'b1;
         end else if (state == REQ_HI && ack_s) begin
            hs_req  <= 1'b0;
         end
         // Timeout only reports; the handshake keeps running.
         if (to_hit)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_c3lib_hs4_src_sync.sv
// Directed bench for the 4-phase source synchronizer.
// Destination side is a small ack model with a receive queue.
module tb_c3lib_hs4_src_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_ready;
   logic       hs_req;
   logic [7:0] hs_data;
   logic       hs_ack;
   logic       tx_done;
   logic       timeout_err;

   logic       auto_en;
   logic       ack_man;
   logic       ack_m = 1'b0;
   logic       rnd;
   int         fix_dly;
   int         mcnt = 0;
   int         mdly = 3;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_done = 0;
   int         hold_bad = 0;
   logic       busy = 1'b0;
   logic [7:0] cap;
   logic [7:0] rx[$];
   logic [7:0] ex[$];

   assign hs_ack = auto_en ? ack_m : ack_man;

   c3lib_hs4_src_sync #(
      .DWIDTH          (8),
      .ACK_SYNC_STAGES (2),
      .TIMEOUT_CYC     (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .hs_req      (hs_req),
      .hs_data     (hs_data),
      .hs_ack      (hs_ack),
      .tx_done     (tx_done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Monitor: pulse count, hs_data hold check, destination model.
   always @(negedge clk) begin
      if (tx_done) n_done++;
      if (rst) begin
         busy = 1'b0;
      end else if (!busy && hs_req) begin
         busy = 1'b1;
         cap  = hs_data;
      end else if (busy) begin
         if (hs_data !== cap) hold_bad++;
         if (tx_done) busy = 1'b0;
      end
      if (!auto_en) begin
         ack_m <= 1'b0;
         mcnt = 0;
      end else if (hs_req && !ack_m) begin
         if (mcnt >= mdly) begin
            ack_m <= 1'b1;
            rx.push_back(hs_data);
            mcnt = 0;
            mdly = rnd ? int'($urandom_range(0, 15)) : fix_dly;
         end else mcnt++;
      end else if (!hs_req && ack_m) begin
         if (mcnt >= mdly) begin
            ack_m <= 1'b0;
            mcnt = 0;
            mdly = rnd ? int'($urandom_range(0, 15)) : fix_dly;
         end else mcnt++;
      end else begin
         mcnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_tx(input int lim);
      for (int g = 0; g < lim; g++) begin
         tick();
         if (tx_done) break;
      end
   endtask

   initial begin
      logic [6:0] exp_rdy;
      int base;
      int acc;
      int bad;
      int stall;

      rst = 1'b1; src_valid = 1'b0; src_data = 8'h00;
      auto_en = 1'b0; ack_man = 1'b0; rnd = 1'b0; fix_dly = 3;
      tick(); tick();
      chk("rst_req", hs_req, 0);
      chk("rst_data", hs_data, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_to", timeout_err, 0);
      chk("rst_rdy", src_ready, 0);
      rst = 1'b0;
      chk("rdy_before_edge", src_ready, 0);
      tick();
      chk("rdy_after_edge", src_ready, 1);

      // Basic transfer
      auto_en = 1'b1;
      rx.delete();
      src_valid = 1'b1; src_data = 8'hA5;
      tick();
      src_valid = 1'b0; src_data = 8'h5A;
      chk("basic_req", hs_req, 1);
      chk("basic_data", hs_data, 8'hA5);
      chk("basic_busy_rdy", src_ready, 0);
      wait_tx(100);
      chk("basic_done", tx_done, 1);
      chk("basic_data_end", hs_data, 8'hA5);
      chk("basic_rdy_back", src_ready, 1);
      tick();
      chk("basic_pulse_1cyc", tx_done, 0);
      chk("basic_rx_cnt", rx.size(), 1);
      if (rx.size() > 0) chk("basic_rx", rx[0], 8'hA5);

      // Back-to-back with src_valid held high
      rx.delete();
      base = n_done; acc = 0;
      src_valid = 1'b1; src_data = 8'h01;
      for (int g = 0; g < 500 && acc < 3; g++) begin
         if (src_ready) begin
            tick();
            acc++;
            src_data = 8'(acc + 1);
            if (acc == 3) src_valid = 1'b0;
         end else tick();
      end
      src_valid = 1'b0;
      for (int g = 0; g < 100 && n_done - base < 3; g++) tick();
      chk("b2b_accepts", acc, 3);
      chk("b2b_done_cnt", n_done - base, 3);
      chk("b2b_rx_cnt", rx.size(), 3);
      if (rx.size() == 3) begin
         chk("b2b_rx0", rx[0], 8'h01);
         chk("b2b_rx1", rx[1], 8'h02);
         chk("b2b_rx2", rx[2], 8'h03);
      end
      chk("hold_stable", hold_bad, 0);

      // Stale ack while idle
      auto_en = 1'b0;
      tick(); tick(); tick();
      exp_rdy = 7'b1000001;
      ack_man = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 4) ack_man = 1'b0;
         chk($sformatf("stale_rdy%0d", k + 1), src_ready, exp_rdy[k]);
         chk($sformatf("stale_req%0d", k + 1), hs_req, 0);
      end
      chk("stale_no_to", timeout_err, 0);

      // Timeout: ack withheld for 20 cycles
      chk("to_pre", timeout_err, 0);
      src_valid = 1'b1; src_data = 8'hC3;
      chk("to_rdy", src_ready, 1);
      tick();
      src_valid = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("to_at9", timeout_err, 0);
      tick();
      chk("to_at10", timeout_err, 1);
      chk("to_req_held", hs_req, 1);
      for (int k = 11; k <= 20; k++) tick();
      ack_man = 1'b1;
      for (int g = 0; g < 20 && hs_req; g++) tick();
      chk("to_req_fall", hs_req, 0);
      ack_man = 1'b0;
      wait_tx(20);
      chk("to_done", tx_done, 1);
      chk("to_data", hs_data, 8'hC3);
      tick(); tick();
      chk("to_sticky", timeout_err, 1);

      // Reset in the middle of REQ_HI
      src_valid = 1'b1; src_data = 8'h3C;
      chk("mr_rdy", src_ready, 1);
      tick();
      src_valid = 1'b0;
      tick(); tick(); tick();
      chk("mr_req_hi", hs_req, 1);
      rst = 1'b1;
      tick();
      chk("mr_req", hs_req, 0);
      chk("mr_data", hs_data, 0);
      chk("mr_done", tx_done, 0);
      chk("mr_to_clr", timeout_err, 0);
      chk("mr_rdy_in_rst", src_ready, 0);
      rst = 1'b0;
      base = n_done;
      tick(); tick(); tick();
      chk("mr_no_done", n_done - base, 0);
      chk("mr_rdy_back", src_ready, 1);

      // Randomized ack delays, 1000 words
      rx.delete(); ex.delete();
      rnd = 1'b1; auto_en = 1'b1;
      base = n_done; stall = 0;
      for (int w = 0; w < 1000; w++) begin
         src_data = 8'($urandom);
         src_valid = 1'b1;
         for (int g = 0; g < 200 && !src_ready; g++) tick();
         if (!src_ready) stall++;
         else ex.push_back(src_data);
         tick();
      end
      src_valid = 1'b0;
      for (int g = 0; g < 300 && n_done - base < 1000; g++) tick();
      chk("rnd_stall", stall, 0);
      chk("rnd_done_cnt", n_done - base, 1000);
      chk("rnd_rx_cnt", rx.size(), ex.size());
      bad = 0;
      for (int i = 0; i < ex.size() && i < rx.size(); i++)
         if (rx[i] !== ex[i]) bad++;
      chk("rnd_scoreboard", bad, 0);
      chk("rnd_hold", hold_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/c3lib_hs4_src_sync.md
C3LIB_HS4_SRC_SYNC -- requirements
Module: c3lib_hs4_src_sync

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning payload width in bits (1..64).
REQ-002 The block SHALL have parameter ACK_SYNC_STAGES, default 2, meaning flop stages on the hs_ack synchronizer (minimum 2).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1023, meaning clk cycles allowed per handshake phase before a timeout is flagged; 0 disables the timeout.
REQ-004 Port clk, input, 1, the single block clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port src_valid, input, 1, local request to send src_data.
REQ-007 Port src_data, input, DWIDTH, payload from the local side.
REQ-008 Port src_ready, output, 1, block can accept a word this cycle.
REQ-009 Port hs_req, output, 1, 4-phase request to the destination domain, driven directly from a flop.
REQ-010 Port hs_data, output, DWIDTH, payload held for the destination domain, driven directly from flops.
REQ-011 Port hs_ack, input, 1, 4-phase acknowledge from the destination domain, asynchronous to clk.
REQ-012 Port tx_done, output, 1, one-cycle pulse when a handshake completes.
REQ-013 Port timeout_err, output, 1, sticky flag set when a handshake phase exceeds TIMEOUT_CYC.

Function
REQ-014 hs_ack SHALL pass through ACK_SYNC_STAGES flops, all reset to 0, before any use; ack_s denotes the last stage.
REQ-015 The FSM SHALL have three states: IDLE, REQ_HI (wait ack_s=1) and REQ_LO (wait ack_s=0).
REQ-016 src_ready SHALL be 1 only in IDLE with ack_s=0.
REQ-017 On a cycle with src_valid=1 and src_ready=1, src_data SHALL be captured into hs_data, hs_req SHALL be 1 from the next cycle, and the FSM SHALL move to REQ_HI.
REQ-018 In REQ_HI with ack_s=1, hs_req SHALL clear on the next edge and the FSM SHALL move to REQ_LO.
REQ-019 In REQ_LO with ack_s=0, the FSM SHALL return to IDLE and tx_done SHALL be 1 for exactly that following cycle.
REQ-020 hs_data SHALL not change from capture until the FSM returns to IDLE.
REQ-021 src_data and src_valid SHALL be ignored outside the accept cycle; there SHALL be no internal queueing.
REQ-022 ack_s=1 while in IDLE (stale or violating acknowledge) SHALL hold src_ready at 0 until ack_s returns to 0 and SHALL not set timeout_err.
REQ-023 The phase counter SHALL clear on every state change and increment each cycle in REQ_HI or REQ_LO, saturating at its maximum value.
REQ-024 When the phase counter reaches TIMEOUT_CYC (with TIMEOUT_CYC>0), timeout_err SHALL set; the handshake SHALL continue normally and SHALL not be aborted.
REQ-025 timeout_err SHALL clear only on rst.
REQ-026 The counter width SHALL be clog2(TIMEOUT_CYC+1), minimum 1.

Reset
REQ-027 On any clk edge with rst=1: FSM=IDLE, hs_req=0, hs_data=0, all sync stages=0, counter=0, tx_done=0, timeout_err=0.
REQ-028 Reset asserted mid-handshake SHALL drop hs_req at that same edge; the destination is responsible for recovering from the aborted handshake.
REQ-029 src_ready SHALL be 0 while rst=1 and SHALL not assert before the edge after rst deasserts.

Structure
REQ-030 State encoding (hs4_state_e: IDLE, REQ_HI, REQ_LO) SHALL live in shared package c3lib_hs4_pkg, together with the clog2-based counter-width function.
REQ-031 The ack synchronizer SHALL be a separate sub-module, c3lib_sync_srst_behav, with parameters RESET_VAL and SYNC_STAGES and a synchronous active-high reset.
REQ-032 The sub-module SHALL be a tool don't-touch cell boundary.

Verification
REQ-033 Basic transfer: DWIDTH=8, send 0xA5; destination model acks 3 cycles after hs_req rises and drops ack 3 cycles after hs_req falls -> hs_data=0xA5 stable throughout, one tx_done pulse, src_ready returns to 1.
REQ-034 Back-to-back: src_valid held high with data 0x01, 0x02, 0x03 -> each word accepted only in IDLE, three tx_done pulses, no word lost or duplicated.
REQ-035 Timeout: TIMEOUT_CYC=10, ack withheld for 20 cycles then given -> timeout_err=1 from cycle 10, handshake completes, timeout_err remains 1.
REQ-036 Stale ack: hs_ack=1 in IDLE for 5 cycles -> src_ready=0 during that time plus ACK_SYNC_STAGES cycles of latency, no FSM transition.
REQ-037 Mid-handshake reset: rst pulsed in REQ_HI -> hs_req=0 and FSM=IDLE on that edge, hs_data=0, no tx_done.
REQ-038 Randomized ack delays of 0..15 cycles over 1000 words -> destination scoreboard matches the source stream exactly.
